// File: rtl/lifo_mc_if.sv
// Push/pop request bus and per-channel status for the multi-channel LIFO.
// The slave side is the stack; the master side is the requester.
interface lifo_mc_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8,
    parameter int NCH    = 4
);
    localparam int CWIDTH = (NCH > 1) ? $clog2(NCH) : 1;

    logic                     wrreq_i;
    logic [CWIDTH-1:0]        wr_ch_i;
    logic [DWIDTH-1:0]        data_i;
    logic                     rdreq_i;
    logic [CWIDTH-1:0]        rd_ch_i;
    logic [DWIDTH-1:0]        q_o;
    logic                     q_valid_o;
    logic [NCH-1:0]           empty_o;
    logic [NCH-1:0]           almost_empty_o;
    logic [NCH-1:0]           almost_full_o;
    logic [NCH-1:0]           full_o;
    logic [NCH*(AWIDTH+1)-1:0] usedw_o;
    logic [1:0]               err_o;

    modport slave (
        input  wrreq_i, wr_ch_i, data_i, rdreq_i, rd_ch_i,
        output q_o, q_valid_o, empty_o, almost_empty_o, almost_full_o, full_o, usedw_o, err_o
    );
    modport master (
        output wrreq_i, wr_ch_i, data_i, rdreq_i, rd_ch_i,
        input  q_o, q_valid_o, empty_o, almost_empty_o, almost_full_o, full_o, usedw_o, err_o
    );
endinterface

// File: rtl/lifo_mc.sv
// Multi-channel LIFO: NCH stacks sharing one memory, one push and one pop per cycle.
// Optional sticky overflow/underflow flags when LIFO_MC_ERR_EN is defined.
module lifo_mc_ch #(
    parameter int AWIDTH       = 8,
    parameter int ALMOST_FULL  = 2,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inc,
    input  logic              dec,
    output logic [AWIDTH:0]   usedw,
    output logic              empty,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              full
);
    localparam int UW = AWIDTH + 1;
    localparam logic [UW-1:0] DEPTH_W = UW'(1 << AWIDTH);
    localparam logic [UW-1:0] AF_TH   = UW'((1 << AWIDTH) - ALMOST_FULL);
    localparam logic [UW-1:0] AE_TH   = UW'(ALMOST_EMPTY);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)          usedw <= '0;
        else if (inc && !dec) usedw <= usedw + UW'(1);
        else if (dec && !inc) usedw <= usedw - UW'(1);
    end

    assign empty        = (usedw == '0);
    assign full         = (usedw == DEPTH_W);
    assign almost_full  = (usedw >= AF_TH);
    assign almost_empty = (usedw <= AE_TH);
endmodule

module lifo_mc #(
    parameter int DWIDTH       = 16,
    parameter int AWIDTH       = 8,
    parameter int NCH          = 4,
    parameter int ALMOST_FULL  = 2,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    lifo_mc_if.slave  bus
);
    localparam int CWIDTH = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int UW     = AWIDTH + 1;
    localparam int DEPTH  = 1 << AWIDTH;
    localparam logic [UW-1:0] DEPTH_W = UW'(DEPTH);

    logic [NCH-1:0][UW-1:0] usedw;
    logic [NCH-1:0]         inc, dec;
    logic [DWIDTH-1:0]      mem [NCH*DEPTH];

    logic                   wr_in, rd_in, same, pop_ok, push_ok;
    logic [UW-1:0]          wr_cnt, rd_cnt, wr_slot, rd_slot;
    logic [CWIDTH+AWIDTH-1:0] wr_addr, rd_addr;
    logic [DWIDTH-1:0]      q;
    logic                   q_valid;

    assign wr_in  = int'(bus.wr_ch_i) < NCH;
    assign rd_in  = int'(bus.rd_ch_i) < NCH;
    assign wr_cnt = wr_in ? usedw[bus.wr_ch_i] : '0;
    assign rd_cnt = rd_in ? usedw[bus.rd_ch_i] : '0;
    assign same   = (bus.wr_ch_i == bus.rd_ch_i);

    // A pop on the same channel frees the top slot, so a full channel can still take the push.
    assign pop_ok  = bus.rdreq_i && rd_in && (rd_cnt != '0);
    assign push_ok = bus.wrreq_i && wr_in && ((wr_cnt != DEPTH_W) || (pop_ok && same));

    assign wr_slot = (pop_ok && same) ? wr_cnt - UW'(1) : wr_cnt;
    assign rd_slot = rd_cnt - UW'(1);
    assign wr_addr = {bus.wr_ch_i, wr_slot[AWIDTH-1:0]};
    assign rd_addr = {bus.rd_ch_i, rd_slot[AWIDTH-1:0]};

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_addr] <= bus.data_i;
    end

    // Read uses the pre-edge memory, so a combined push+pop returns the old top.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= pop_ok;
            if (pop_ok) q <= mem[rd_addr];
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign inc[k] = push_ok && (bus.wr_ch_i == CWIDTH'(k));
        assign dec[k] = pop_ok  && (bus.rd_ch_i == CWIDTH'(k));
        lifo_mc_ch #(
            .AWIDTH(AWIDTH), .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY)
        ) u_ch (
            .clk_i(clk_i), .rst_ni(rst_ni), .inc(inc[k]), .dec(dec[k]),
            .usedw(usedw[k]), .empty(bus.empty_o[k]), .almost_empty(bus.almost_empty_o[k]),
            .almost_full(bus.almost_full_o[k]), .full(bus.full_o[k])
        );
    end

    assign bus.usedw_o   = usedw;
    assign bus.q_o       = q;
    assign bus.q_valid_o = q_valid;

`ifdef LIFO_MC_ERR_EN
    logic [1:0] err;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err <= 2'b00;
        else begin
            if (bus.wrreq_i && !push_ok) err[1] <= 1'b1;
            if (bus.rdreq_i && !pop_ok)  err[0] <= 1'b1;
        end
    end
    assign bus.err_o = err;
`else
    assign bus.err_o = 2'b00;
`endif
endmodule

// File: doc/lifo_mc.md
# lifo_mc

Multi-channel LIFO stack: NCH independent stacks of depth 2^AWIDTH share one memory array, each with its own pointer, occupancy counter and status flags. It replaces the single-channel LIFO where several producers or contexts need separate stacks, such as per-thread return stacks or per-channel reordering buffers, without instantiating one memory per channel. One push and one pop are accepted per cycle, to the same channel or to different channels.

## Interface
Parameters:
- DWIDTH, 16, data word width
- AWIDTH, 8, log2 of per-channel depth; DEPTH = 2^AWIDTH
- NCH, 4, number of channels (>= 1)
- CWIDTH, $clog2(NCH) (min 1), channel-select width (derived, not overridden)
- ALMOST_FULL, 2, almost_full asserted when usedw >= DEPTH - ALMOST_FULL
- ALMOST_EMPTY, 2, almost_empty asserted when usedw <= ALMOST_EMPTY

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_ni  in  1  reset, asynchronous assert, active-low
- wrreq_i  in  1  push request
- wr_ch_i  in  CWIDTH  push channel
- data_i  in  DWIDTH  push data
- rdreq_i  in  1  pop request
- rd_ch_i  in  CWIDTH  pop channel
- q_o  out  DWIDTH  popped word, registered
- q_valid_o  out  1  q_o holds the result of an accepted pop
- empty_o  out  NCH  per-channel empty
- almost_empty_o  out  NCH  per-channel almost empty
- almost_full_o  out  NCH  per-channel almost full
- full_o  out  NCH  per-channel full
- usedw_o  out  NCH*(AWIDTH+1)  packed per-channel occupancy; channel k occupies bits [k*(AWIDTH+1) +: AWIDTH+1]
- err_o  out  2  sticky {overflow, underflow}; see Configuration

## Operation
- Memory: NCH*DEPTH words, addressed {ch, ptr}. Per-channel usedw[k] ranges 0..DEPTH. The top of stack is at ptr = usedw[k]-1.
- A push to channel c is accepted if !full[c], or if a pop to the same channel c is accepted in the same cycle. The word is written at usedw[c], or at usedw[c]-1 when combined with a pop.
- A pop from channel c is accepted if !empty[c]. The memory location usedw[c]-1 is read and q_o is loaded on the next edge.
- Accepted push and pop on the same channel in the same cycle:
  - q_o gets the old top.
  - data_i replaces the top slot.
  - usedw is unchanged. This holds when the channel is full as well.
- Push and pop on the same empty channel in the same cycle: the pop is rejected and the push is performed. usedw goes to 1 and q_valid_o is 0.
- Push and pop on different channels proceed independently.
- A rejected request leaves memory, pointers, flags and q_o untouched.
- Flags are derived from registered usedw:
  - empty = (usedw == 0)
  - full = (usedw == DEPTH)
  - almost thresholds as given under Interface
- Out-of-range channel (ch >= NCH) is treated as a rejected request.

## Timing
- Reset (rst_ni low, asynchronous) drives:
  - usedw_o = 0, empty_o = all 1, almost_empty_o = all 1
  - full_o = 0, almost_full_o = 0
  - q_o = 0, q_valid_o = 0, err_o = 0
- Memory contents are not reset.
- Pop latency is 1: rdreq_i is sampled at edge N, and q_o/q_valid_o are valid after edge N. q_valid_o is high for exactly one cycle per accepted pop. q_o holds its value until the next accepted pop.
- usedw_o and all flags update at the same edge that accepts the request.
- Back-to-back pops on the same channel every cycle return consecutive older words with no bubbles.
- Deassertion of rst_ni must be synchronised externally. The first request is honoured on the first rising edge with rst_ni high.

## Configuration
- LIFO_MC_ERR_EN defined:
  - err_o[1] (overflow) sets on a push rejected because the channel is full.
  - err_o[0] (underflow) sets on a pop rejected because the channel is empty, including the push+pop-on-empty case.
  - Out-of-range channel requests set the corresponding bit.
  - Both bits are sticky until reset.
- LIFO_MC_ERR_EN undefined: err_o is tied to 2'b00 and no error logic is synthesised. Data-path behaviour is identical in both builds.

## Test plan
- Reset then idle, NCH=4, AWIDTH=3 -> empty_o=4'hF, almost_empty_o=4'hF, full_o=0, usedw_o=0, q_valid_o=0.
- Push 1..8 into ch2, then pop 8 times -> q_o = 8,7,...,1, each one cycle after its pop. full_o[2] is high after the 8th push and almost_full_o[2] from usedw=6. Other channels remain empty throughout.
- Push 0xA into ch0 and 0xB into ch1, then pop ch0 and push ch1 in the same cycle -> q_o=0xA, usedw ch0=0, ch1=2.
- ch3 full with top=0x55; push 0x77 and pop ch3 in the same cycle -> q_o=0x55, usedw stays 8, the next pop returns 0x77.
- Push+pop on empty ch1 -> q_valid_o=0, usedw ch1=1. With LIFO_MC_ERR_EN, err_o=2'b01.
- Assert rst_ni mid-sequence with ch0 usedw=5 -> all outputs return to reset values immediately, without waiting for a clock edge. The next pop on ch0 is rejected.
